// File: rtl/sonic_ranger.sv
`default_nettype none
// ============================================================================
// Module      : sonic_ranger
// Description : HC-SR04 style ultrasonic range controller. Fires a periodic
//               trigger, times the echo and converts its width to millimetres
//               by prescaled counting. Define SONIC_AVG_EN to report a 4-entry
//               running average instead of the raw result.
// Revision    : 1.0 - initial release
// ============================================================================
module sonic_ranger #(
    parameter int TRIG_CYCLES    = 1000,
    parameter int PERIOD_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 3_800_000,
    parameter int CYC_PER_MM     = 583
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        echo,
    output logic        trig,
    output logic [19:0] distance,
    output logic        valid,
    output logic        timeout,
    output logic        busy
);

    localparam int c_PW   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int c_CMAX = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int c_CW   = $clog2(c_CMAX + 1);
    localparam int c_SW   = (CYC_PER_MM > 1) ? $clog2(CYC_PER_MM) : 1;

    localparam logic [c_PW-1:0] c_PERIOD_LAST = c_PW'(PERIOD_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TRIG_LAST   = c_CW'(TRIG_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TO_LAST     = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_SW-1:0] c_PRESC_LAST  = c_SW'(CYC_PER_MM - 1);
    localparam logic [19:0]     c_MM_MAX      = 20'hFFFFF;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_TRIG = 3'd1;
    localparam logic [2:0] c_S_WAIT = 3'd2;
    localparam logic [2:0] c_S_MEAS = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    logic            echo_meta_q;
    logic            echo_s_q;
    logic [c_PW-1:0] period_q;

    logic [2:0]      state_q,    state_d;
    logic [c_CW-1:0] cyc_q,      cyc_d;
    logic [c_SW-1:0] presc_q,    presc_d;
    logic [19:0]     mm_q,       mm_d;
    logic            to_res_q,   to_res_d;
    logic            trig_q,     trig_d;
    logic            busy_q,     busy_d;
    logic            valid_q,    valid_d;
    logic            timeout_q,  timeout_d;
    logic [19:0]     distance_q, distance_d;

    logic            w_start;
    logic            w_presc_wrap;
    logic [c_SW-1:0] w_presc_inc;
    logic [19:0]     w_mm_inc;
    logic [19:0]     w_result;

`ifdef SONIC_AVG_EN
    logic [3:0][19:0] hist_q, hist_d;
    logic             hist_loaded_q, hist_loaded_d;
    logic [3:0][19:0] w_hist_new;
    logic [21:0]      w_sum;
`endif

    // Period counter is 0 on the first cycle after reset, giving an immediate start
    assign w_start = (period_q == '0);

    // One echo-high cycle worth of prescaled counting; mm_count saturates
    assign w_presc_wrap = (presc_q == c_PRESC_LAST);
    assign w_presc_inc  = w_presc_wrap ? '0 : presc_q + 1'b1;
    assign w_mm_inc     = (w_presc_wrap && (mm_q != c_MM_MAX)) ? mm_q + 20'd1 : mm_q;
    assign w_result     = to_res_q ? c_MM_MAX : mm_q;

`ifdef SONIC_AVG_EN
    // First result after reset fills the whole history so the average starts flat
    assign w_hist_new = hist_loaded_q ? {hist_q[2:0], w_result} : {4{w_result}};
    assign w_sum      = 22'(w_hist_new[0]) + 22'(w_hist_new[1])
                      + 22'(w_hist_new[2]) + 22'(w_hist_new[3]);
`endif

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        presc_d    = presc_q;
        mm_d       = mm_q;
        to_res_d   = to_res_q;
        trig_d     = trig_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
        distance_d = distance_q;
`ifdef SONIC_AVG_EN
        hist_d        = hist_q;
        hist_loaded_d = hist_loaded_q;
`endif
        case (state_q)
            c_S_IDLE: begin
                if (w_start) begin
                    state_d  = c_S_TRIG;
                    trig_d   = 1'b1;
                    busy_d   = 1'b1;
                    cyc_d    = '0;
                    presc_d  = '0;
                    mm_d     = '0;
                    to_res_d = 1'b0;
                end
            end
            c_S_TRIG: begin
                if (cyc_q == c_TRIG_LAST) begin
                    trig_d  = 1'b0;
                    state_d = c_S_WAIT;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            c_S_WAIT: begin
                // The rising cycle is itself the first echo-high cycle
                if (echo_s_q) begin
                    state_d = c_S_MEAS;
                    cyc_d   = c_CW'(1);
                    presc_d = w_presc_inc;
                    mm_d    = w_mm_inc;
                end else if (cyc_q == c_TO_LAST) begin
                    state_d  = c_S_DONE;
                    to_res_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            c_S_MEAS: begin
                if (!echo_s_q) begin
                    state_d = c_S_DONE;
                end else begin
                    presc_d = w_presc_inc;
                    mm_d    = w_mm_inc;
                    if (cyc_q == c_TO_LAST) begin
                        state_d  = c_S_DONE;
                        to_res_d = 1'b1;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            c_S_DONE: begin
                state_d   = c_S_IDLE;
                busy_d    = 1'b0;
                valid_d   = 1'b1;
                timeout_d = to_res_q;
`ifdef SONIC_AVG_EN
                hist_d        = w_hist_new;
                hist_loaded_d = 1'b1;
                distance_d    = 20'(w_sum >> 2);
`else
                distance_d    = w_result;
`endif
            end
            default: begin
                state_d = c_S_IDLE;
                trig_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            period_q   <= '0;
            state_q    <= c_S_IDLE;
            cyc_q      <= '0;
            presc_q    <= '0;
            mm_q       <= '0;
            to_res_q   <= 1'b0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            distance_q <= '0;
        end else begin
            period_q   <= (period_q == c_PERIOD_LAST) ? '0 : period_q + 1'b1;
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            presc_q    <= presc_d;
            mm_q       <= mm_d;
            to_res_q   <= to_res_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            distance_q <= distance_d;
        end
    end

`ifdef SONIC_AVG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q        <= '0;
            hist_loaded_q <= 1'b0;
        end else begin
            hist_q        <= hist_d;
            hist_loaded_q <= hist_loaded_d;
        end
    end
`endif

    assign trig     = trig_q;
    assign distance = distance_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: doc/sonic_ranger.md
Name: sonic_ranger

Overview:
- Ultrasonic range-finder controller (HC-SR04 style) that produces the 20-bit `distance` bus consumed by the distance seven-segment display.
- Periodically fires a trigger pulse, times the echo pulse with the system clock, and converts the width to millimetres by prescaled counting (no divider).
- Sits between the sensor header pins and the display/navigation logic of the cleaning robot.

Parameters:
- TRIG_CYCLES, 1000, trigger high time in clk cycles (10 us at 100 MHz).
- PERIOD_CYCLES, 10_000_000, cycles from one trigger rise to the next (100 ms).
- TIMEOUT_CYCLES, 3_800_000, maximum wait for echo rise, and maximum echo high time (38 ms each).
- CYC_PER_MM, 583, echo-high cycles per millimetre of range (round trip at 343 m/s).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-low reset.
- echo  input  1  raw sensor echo, asynchronous to clk.
- trig  output  1  sensor trigger pulse.
- distance  output  20  last measured range in mm, held between measurements.
- valid  output  1  one-cycle pulse when `distance` updates.
- timeout  output  1  one-cycle pulse coincident with `valid` when the measurement timed out.
- busy  output  1  high from trigger rise until measurement completes.

Behaviour:
- Reset (rst==0 at a clk edge):
  - trig=0, distance=0, valid=0, timeout=0, busy=0.
  - All counters cleared; FSM enters IDLE.
  - Synchronizer flops cleared.
  - Reset applies mid-measurement, aborting it without a `valid` pulse.
- echo passes through a 2-FF synchronizer; echo_s is the synced value.
  - Latency of 2 cycles is absorbed into the count and is not compensated.
- The period counter runs freely 0..PERIOD_CYCLES-1 and wraps to 0. Each wrap to 0, and the first cycle after reset release, issues a start request.
- FSM:
  - IDLE: busy=0. On start request, go to TRIG, set busy=1, clear the cycle and mm counters.
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles, then trig=0 and go to WAIT_RISE.
  - WAIT_RISE: wait for echo_s==1.
    - On echo_s==1, go to MEASURE.
    - After TIMEOUT_CYCLES cycles without a rise, go to DONE with the timeout result.
  - MEASURE, each cycle with echo_s==1:
    - Prescaler increments; at CYC_PER_MM-1 it wraps to 0 and mm_count increments.
    - mm_count saturates at 20'hFFFFF.
    - On echo_s==0, go to DONE with the normal result.
    - After TIMEOUT_CYCLES echo-high cycles, go to DONE with the timeout result.
  - DONE (one cycle): update outputs, then go to IDLE with busy=0.
    - Normal result: distance<=mm_count, valid=1, timeout=0.
    - Timeout result: distance<=20'hFFFFF, valid=1, timeout=1.
- Truncation: a partial final millimetre (prescaler not wrapped) is discarded.
- A start request arriving while not in IDLE is dropped; the period counter keeps running.
- An echo already high on entry to WAIT_RISE counts as the rise on that cycle.
- `distance` is registered and changes only in DONE or on reset.

Optional Feature:
- Macro: SONIC_AVG_EN.
- When defined:
  - A 4-entry history of results is kept.
  - The first result after reset loads all four entries.
  - Each later result shifts in, replacing the oldest.
  - distance <= (sum of the 4 entries) >> 2, using a 22-bit sum and truncating division.
  - Timeout results (20'hFFFFF) enter the history like any other result.
  - valid and timeout timing are unchanged.
  - The history clears on reset.
- When undefined: `distance` is the raw result as specified above, and no history registers exist.

Test Plan:
- Bench parameters: TRIG_CYCLES=10, PERIOD_CYCLES=2000, TIMEOUT_CYCLES=500, CYC_PER_MM=5.
- Reset then release, echo held 0 → trig high for exactly 10 cycles starting 1 cycle after release, busy=1; 500 cycles later valid=1, timeout=1, distance=20'hFFFFF.
- Echo rises 20 cycles after trig falls and stays high 103 cycles → valid=1, timeout=0, distance=20 (partial mm discarded).
- Echo high 600 cycles → timeout=1 at the 500th high cycle, distance=20'hFFFFF; trig fires again at the next period wrap (2000 cycles after the previous rise).
- rst driven 0 during MEASURE → next edge: trig=0, busy=0, distance=0, no valid pulse; measurement restarts on release.
- SONIC_AVG_EN defined, echo widths 50, 100, 150, 200 cycles (10, 20, 30, 40 mm) → distance sequence 10, 12, 17, 25.
